// File: rtl/cp0_regfile_if.sv
// CP0 register file bus: MTC0/MFC0 access, exception/ERET commit and status outputs.
interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] exc_badvaddr_i;
  logic        eret_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;
  logic        int_req_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i,
    output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    input  rdata_o, status_o, cause_o, epc_o, timer_int_o, int_req_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i,
    input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
    output rdata_o, status_o, cause_o, epc_o, timer_int_o, int_req_o
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS-style CP0 subset: BadVAddr, Count/Compare timer, Status, Cause, EPC with
// exception/ERET sequencing and interrupt request generation.
module cp0_regfile (
  input  logic           clk,
  input  logic           rst,
  cp0_regfile_if.slave   bus
);
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] EXC_ADEL     = 5'd4;
  localparam logic [4:0] EXC_ADES     = 5'd5;

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_q, timer_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;

  logic        mtc0_ok;
  logic [31:0] status_w, cause_w;
  logic [7:0]  ip_w;

  // Exception and ERET own Status/Cause/EPC this cycle; MTC0 to them is dropped.
  assign mtc0_ok  = bus.we_i & ~bus.exc_valid_i & ~bus.eret_i;

  assign ip_w     = {ip_hw_q, ip_sw_q};
  assign status_w = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_w  = {bd_q, 15'b0, ip_w, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    tick_d     = ~tick_q;
    count_d    = tick_q ? count_q + 32'd1 : count_q;
    compare_d  = compare_q;
    timer_d    = timer_q;
    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    ip_hw_d    = {bus.int_i[5] | timer_q, bus.int_i[4:0]};

    if (bus.we_i && bus.waddr_i == REG_COUNT) count_d = bus.wdata_i;

    if (bus.we_i && bus.waddr_i == REG_COMPARE) begin
      compare_d = bus.wdata_i;
      timer_d   = 1'b0;
    end else if (count_q == compare_q && compare_q != 32'd0) begin
      timer_d = 1'b1;
    end

    if (bus.exc_valid_i) begin
      if (!exl_q) begin
        epc_d = bus.exc_bd_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
        bd_d  = bus.exc_bd_i;
      end
      exl_d      = 1'b1;
      exc_code_d = bus.exc_code_i;
      if (bus.exc_code_i == EXC_ADEL || bus.exc_code_i == EXC_ADES)
        badvaddr_d = bus.exc_badvaddr_i;
    end else if (bus.eret_i) begin
      exl_d = 1'b0;
    end else if (mtc0_ok) begin
      case (bus.waddr_i)
        REG_STATUS: begin
          im_d  = bus.wdata_i[15:8];
          exl_d = bus.wdata_i[1];
          ie_d  = bus.wdata_i[0];
        end
        REG_CAUSE: ip_sw_d = bus.wdata_i[9:8];
        REG_EPC:   epc_d   = bus.wdata_i;
        default:   ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      badvaddr_q <= '0;
      epc_q      <= '0;
      timer_q    <= 1'b0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
    end else begin
      tick_q     <= tick_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      timer_q    <= timer_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
    end
  end

  always_comb begin
    case (bus.raddr_i)
      REG_BADVADDR: bus.rdata_o = badvaddr_q;
      REG_COUNT:    bus.rdata_o = count_q;
      REG_COMPARE:  bus.rdata_o = compare_q;
      REG_STATUS:   bus.rdata_o = status_w;
      REG_CAUSE:    bus.rdata_o = cause_w;
      REG_EPC:      bus.rdata_o = epc_q;
      default:      bus.rdata_o = '0;
    endcase
  end

  assign bus.status_o    = status_w;
  assign bus.cause_o     = cause_w;
  assign bus.epc_o       = epc_q;
  assign bus.timer_int_o = timer_q;
  assign bus.int_req_o   = ie_q & ~exl_q & (|(im_q & ip_w));
endmodule
